hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
Multi-cycle control and HI/LO register stage that sits between the execute stage and the combinational divider. It latches the divide operands and holds them stable to the divider for a fixed settle window. It then captures the divider's remainder into HI and quotient into LO, and asserts busy so the pipeline stalls in the meantime. It also owns the HI/LO write paths for MULT/MULTU results and for MTHI/MTLO.

Parameters:
DIV_CYCLES, 4, clock cycles the divider operands are held before R/Q are sampled (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
div_start  input  1  one-cycle request: start DIV/DIVU with in_a, in_b, in_sign
in_sign  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
in_a  input  32  dividend from execute stage
in_b  input  32  divisor from execute stage
div_sign  output  1  registered sign flag driven to the divider
div_a  output  32  registered dividend driven to the divider
div_b  output  32  registered divisor driven to the divider
div_r  input  32  remainder returned by the divider
div_q  input  32  quotient returned by the divider
mult_we  input  1  write mult_hi/mult_lo into HI/LO
mult_hi  input  32  upper product word
mult_lo  input  32  lower product word
mthi  input  1  write wdata into HI
mtlo  input  1  write wdata into LO
wdata  input  32  rs value for MTHI/MTLO
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  divide in progress; pipeline must stall HI/LO consumers and new HI/LO writers
done  output  1  one-cycle pulse: HI/LO updated with a divide result

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, hi=lo=0, div_a=div_b=0, div_sign=0, busy=0, done=0. Reset mid-divide aborts the operation; HI/LO return to 0 and no done pulse is generated.
- States: IDLE, WAIT. busy is registered and equals (state==WAIT).
- done is a registered pulse, high for exactly one cycle.
- IDLE with div_start=1 at edge E0:
  - div_a<=in_a, div_b<=in_b, div_sign<=in_sign.
  - cnt<=DIV_CYCLES-1; state<=WAIT.
- WAIT with cnt!=0: cnt<=cnt-1. Operand registers hold.
- WAIT with cnt==0:
  - hi<=div_r, lo<=div_q.
  - state<=IDLE; done<=1 for the following cycle.
- Timing: HI/LO update at edge E0+DIV_CYCLES. busy is high for DIV_CYCLES cycles after E0. done is high during the cycle after the write.
- Divide by zero: no special handling here. The divider yields R=Q=0, so HI=LO=0 and done pulses normally.
- Write priority in IDLE: div_start > mult_we > {mthi, mtlo}.
  - div_start drops any same-cycle mult_we, mthi or mtlo.
  - mult_we (no div_start): hi<=mult_hi, lo<=mult_lo; mthi/mtlo in the same cycle are dropped.
  - mthi and mtlo together both apply: hi<=wdata, lo<=wdata.
- In WAIT, div_start, mult_we, mthi and mtlo are all ignored. HI/LO change only via the divide completion.
- hi and lo are direct register outputs with no bypass: a write at edge E is visible after E.
- Counter width is 4 bits; DIV_CYCLES=1 means sampling at the first edge after E0.

Test Plan:
- Reset, then DIVU in_a=100 in_b=7 at E0 -> div_a=100 and div_b=7 after E0. busy=1 for 4 cycles. At E0+4: lo=14, hi=2; done=1 for one cycle; busy=0.
- DIV in_sign=1, in_a=0xFFFFFFF9 (-7), in_b=2 -> after 4 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU in_b=0, in_a=0x12345678 -> hi=0, lo=0, done pulses at E0+4.
- Preload hi=0xAAAA0000 via mthi. Start a divide, then assert mthi wdata=0x5555 and mult_we during busy -> both ignored; hi/lo end holding div_r/div_q.
- In IDLE assert div_start, mult_we and mthi in the same cycle -> only the divide proceeds; hi/lo unchanged until completion.
- Assert rst_n=0 two cycles into a divide -> hi=lo=0, busy=0 immediately; no done pulse after release.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// HI/LO register stage: holds divider operands DIV_CYCLES cycles, then captures R->HI, Q->LO.
// Latency DIV_CYCLES edges to result, done pulses one cycle later; busy stalls all HI/LO writers.
module hilo_div_ctrl #(
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_start,
  input  logic        in_sign,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_r,
  input  logic [31:0] div_q,
  input  logic        mult_we,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sign_q, sign_d;
  logic        busy_q, done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      busy_q  <= (state_d == WAIT);
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (div_start) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // HI/LO write priority in IDLE: divide start, then MULT, then MTHI/MTLO.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    a_d    = a_q;
    b_d    = b_q;
    sign_d = sign_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_start) begin
          a_d    = in_a;
          b_d    = in_b;
          sign_d = in_sign;
        end else if (mult_we) begin
          hi_d = mult_hi;
          lo_d = mult_lo;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          hi_d   = div_r;
          lo_d   = div_q;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign div_a    = a_q;
  assign div_b    = b_q;
  assign div_sign = sign_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl with a behavioural combinational divider attached.
module tb_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start, in_sign;
  logic [31:0] in_a, in_b;
  logic        div_sign;
  logic [31:0] div_a, div_b, div_r, div_q;
  logic        mult_we, mthi, mtlo;
  logic [31:0] mult_hi, mult_lo, wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int passed = 0;
  int total  = 0;

  hilo_div_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .div_start(div_start), .in_sign(in_sign), .in_a(in_a), .in_b(in_b),
    .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
    .div_r(div_r), .div_q(div_q),
    .mult_we(mult_we), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Divider environment: zero divisor yields R=Q=0.
  always_comb begin
    div_r = 32'd0;
    div_q = 32'd0;
    if (div_b != 32'd0) begin
      if (div_sign) begin
        div_q = 32'($signed(div_a) / $signed(div_b));
        div_r = 32'($signed(div_a) % $signed(div_b));
      end else begin
        div_q = div_a / div_b;
        div_r = div_a % div_b;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    div_start = 1'b0; in_sign = 1'b0; in_a = 32'd0; in_b = 32'd0;
    mult_we = 1'b0; mult_hi = 32'd0; mult_lo = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
  endtask

  // Starts a divide at E0 and checks busy/hold window, result at E0+4 and the done pulse.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    div_start = 1'b1; in_a = a; in_b = b; in_sign = s;
    step();
    idle_inputs();
    chk({tag, "_div_a"}, div_a, a);
    chk({tag, "_div_b"}, div_b, b);
    chk({tag, "_div_sign"}, {31'd0, div_sign}, {31'd0, s});
    for (int i = 1; i <= 3; i++) begin
      chk({tag, "_busy_hold"}, {31'd0, busy}, 32'd1);
      chk({tag, "_hi_hold"}, hi, hi0);
      chk({tag, "_lo_hold"}, lo, lo0);
      chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
      step();
    end
    chk({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
    step();
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    step();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    rst_n = 1'b1;
    step();

    run_div("divu", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
    run_div("div_neg", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("div_zero", 32'h1234_5678, 32'd0, 1'b0, 32'd0, 32'd0);

    // MULT beats a same-cycle MTHI; then MTHI+MTLO together.
    mult_we = 1'b1; mult_hi = 32'h1111_2222; mult_lo = 32'h3333_4444;
    mthi = 1'b1; wdata = 32'h9999_9999;
    step();
    idle_inputs();
    chk("mult_hi", hi, 32'h1111_2222);
    chk("mult_lo", lo, 32'h3333_4444);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    step();
    idle_inputs();
    chk("mthilo_hi", hi, 32'hCAFE_F00D);
    chk("mthilo_lo", lo, 32'hCAFE_F00D);

    // Writes during WAIT are ignored.
    mthi = 1'b1; wdata = 32'hAAAA_0000;
    step();
    idle_inputs();
    chk("mthi_pre", hi, 32'hAAAA_0000);
    div_start = 1'b1; in_a = 32'd100; in_b = 32'd7;
    step();
    idle_inputs();
    mthi = 1'b1; wdata = 32'h0000_5555;
    mult_we = 1'b1; mult_hi = 32'hDEAD_0001; mult_lo = 32'hDEAD_0002;
    div_start = 1'b1; in_a = 32'd9; in_b = 32'd3;
    step();
    idle_inputs();
    chk("wait_ign_hi", hi, 32'hAAAA_0000);
    chk("wait_ign_lo", lo, 32'hCAFE_F00D);
    chk("wait_ign_div_a", div_a, 32'd100);
    step(); step();
    chk("wait_ign_busy", {31'd0, busy}, 32'd1);
    step();
    chk("wait_ign_res_hi", hi, 32'd2);
    chk("wait_ign_res_lo", lo, 32'd14);
    chk("wait_ign_done", {31'd0, done}, 32'd1);
    step();

    // Divide start wins over same-cycle MULT and MTHI.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_0BAD;
    step();
    idle_inputs();
    div_start = 1'b1; in_a = 32'd50; in_b = 32'd5;
    mult_we = 1'b1; mult_hi = 32'hFFFF_0000; mult_lo = 32'h0000_FFFF;
    mthi = 1'b1; wdata = 32'h1234_0000;
    step();
    idle_inputs();
    chk("prio_hi_hold", hi, 32'h0BAD_0BAD);
    chk("prio_lo_hold", lo, 32'h0BAD_0BAD);
    chk("prio_busy", {31'd0, busy}, 32'd1);
    step(); step(); step();
    chk("prio_hi_hold2", hi, 32'h0BAD_0BAD);
    step();
    chk("prio_hi", hi, 32'd0);
    chk("prio_lo", lo, 32'd10);
    chk("prio_done", {31'd0, done}, 32'd1);
    step();

    // Reset two cycles into a divide aborts it with no done.
    mthi = 1'b1; wdata = 32'h0000_0077;
    step();
    idle_inputs();
    div_start = 1'b1; in_a = 32'd100; in_b = 32'd7;
    step();
    idle_inputs();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_div_a", div_a, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_done", {31'd0, done}, 32'd0);
      chk("abort_no_busy", {31'd0, busy}, 32'd0);
    end
    chk("abort_hi_after", hi, 32'd0);
    chk("abort_lo_after", lo, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
